// File: rtl/bus_arb_pkg.sv
// Shared source IDs and request-bundle sizing for the SRAM bus arbiter.
package bus_arb_pkg;
    localparam int SRC_W = 1;

    typedef enum logic [SRC_W-1:0] {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_t;

    // {wr, wstrb, addr, wdata} as carried through the grant mux
    function automatic int req_bw(input int aw, input int dw);
        return aw + dw + dw / 8 + 1;
    endfunction

    localparam int REQ_W = req_bw(32, 32);
endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each outstanding transaction.
module arb_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr, rd_ptr;

    // explicit wrap so non-power-of-2 depths work
    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_nxt(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_nxt(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between IF (inst) and MEM (data); data has priority,
// a stalled grant is held until accepted, responses are routed via the tag FIFO.
module sram_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    localparam int SW       = DW / 8,
    localparam int CW       = $clog2(MAX_OUTST + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [SW-1:0] data_wstrb,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [SW-1:0] mem_wstrb,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] outst_cnt
);
    localparam int RW = req_bw(AW, DW);

    logic          hold_vld;
    src_t          hold_src;
    logic          sel_vld;
    src_t          src;
    logic          full, empty, accept, pop;
    logic [SRC_W-1:0] head;
    logic [RW-1:0] inst_bundle, data_bundle, mem_bundle;

    assign inst_bundle = {1'b0, SW'(0), inst_addr, DW'(0)};
    assign data_bundle = {data_wr, data_wstrb, data_addr, data_wdata};

    // full uses the registered count, so a same-cycle pop never frees a slot early
    always_comb begin
        sel_vld    = 1'b0;
        src        = SRC_INST;
        mem_bundle = '0;
        if (resetn && !full) begin
            if (hold_vld) begin
                sel_vld = 1'b1;
                src     = hold_src;
            end else if (data_req) begin
                sel_vld = 1'b1;
                src     = SRC_DATA;
            end else if (inst_req) begin
                sel_vld = 1'b1;
                src     = SRC_INST;
            end
        end
        if (sel_vld)
            mem_bundle = (src == SRC_DATA) ? data_bundle : inst_bundle;
    end

    assign mem_req = sel_vld;
    assign {mem_wr, mem_wstrb, mem_addr, mem_wdata} = mem_bundle;

    assign accept       = sel_vld & mem_addr_ok;
    assign inst_addr_ok = accept & (src == SRC_INST);
    assign data_addr_ok = accept & (src == SRC_DATA);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_vld <= 1'b0;
            hold_src <= SRC_INST;
        end else if (sel_vld) begin
            hold_vld <= ~mem_addr_ok;
            hold_src <= src;
        end
    end

    arb_tag_fifo #(.DEPTH(MAX_OUTST), .W(SRC_W)) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept),
        .push_data (src),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .count     (outst_cnt)
    );

    // a response with nothing outstanding is dropped
    assign pop          = resetn & mem_data_ok & ~empty;
    assign inst_data_ok = pop & (head == SRC_INST);
    assign data_data_ok = pop & (head == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed and randomized checks of sram_bus_arbiter against a queue-based reference model.
module tb_sram_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int MAX_OUTST = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          inst_req, inst_addr_ok, inst_data_ok;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr, data_addr_ok, data_data_ok;
    logic [SW-1:0] data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [SW-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] outst_cnt;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUTST(MAX_OUTST), .AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .outst_cnt(outst_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // reference model: owners of outstanding transactions in acceptance order,
    // plus the requester whose offer is waiting for mem_addr_ok
    bit q[$];
    bit m_hold = 1'b0;
    bit m_hold_src = 1'b0;
    bit acc_inst, acc_data;

    task automatic cycle();
        bit e_sel, e_src, e_pop, e_head;
        #1;
        e_sel = 1'b0;
        e_src = 1'b0;
        if (resetn && q.size() < MAX_OUTST) begin
            if (m_hold)        begin e_sel = 1'b1; e_src = m_hold_src; end
            else if (data_req) begin e_sel = 1'b1; e_src = 1'b1; end
            else if (inst_req) begin e_sel = 1'b1; e_src = 1'b0; end
        end
        e_head = (q.size() > 0) ? q[0] : 1'b0;
        e_pop  = resetn && mem_data_ok && (q.size() > 0);
        chk("mem_req", mem_req, e_sel);
        if (e_sel) begin
            chk("mem_addr",  mem_addr,  e_src ? data_addr  : inst_addr);
            chk("mem_wr",    mem_wr,    e_src ? data_wr    : 1'b0);
            chk("mem_wstrb", mem_wstrb, e_src ? data_wstrb : SW'(0));
            chk("mem_wdata", mem_wdata, e_src ? data_wdata : DW'(0));
        end
        chk("inst_addr_ok", inst_addr_ok, e_sel && mem_addr_ok && !e_src);
        chk("data_addr_ok", data_addr_ok, e_sel && mem_addr_ok && e_src);
        chk("inst_data_ok", inst_data_ok, e_pop && !e_head);
        chk("data_data_ok", data_data_ok, e_pop && e_head);
        chk("inst_rdata", inst_rdata, mem_rdata);
        chk("data_rdata", data_rdata, mem_rdata);
        chk("outst_cnt", outst_cnt, q.size());
        acc_inst = e_sel && mem_addr_ok && !e_src;
        acc_data = e_sel && mem_addr_ok && e_src;
        @(posedge clk);
        if (!resetn) begin
            q.delete();
            m_hold = 1'b0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_sel && mem_addr_ok) begin
                q.push_back(e_src);
                m_hold = 1'b0;
            end else if (e_sel) begin
                m_hold     = 1'b1;
                m_hold_src = e_src;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * MAX_OUTST && q.size() > 0; i++) begin
            set_idle();
            mem_data_ok = 1'b1;
            mem_rdata   = $urandom;
            cycle();
        end
        set_idle();
        cycle();
    endtask

    // requesters must hold a request steady until it is accepted
    logic          p_ireq = 1'b0, p_dreq = 1'b0;
    logic [AW-1:0] p_iaddr, p_daddr;
    always @(posedge clk) begin
        if (resetn && p_ireq)
            assert (inst_req && inst_addr == p_iaddr) else $error("inst request changed before accept");
        if (resetn && p_dreq)
            assert (data_req && data_addr == p_daddr) else $error("data request changed before accept");
        p_ireq  <= resetn && inst_req && !inst_addr_ok;
        p_dreq  <= resetn && data_req && !data_addr_ok;
        p_iaddr <= inst_addr;
        p_daddr <= data_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ipend, dpend;
        set_idle();
        @(negedge clk);
        // outputs stay quiet under reset even with requests and a response pending
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        cycle();
        cycle();
        set_idle();
        resetn = 1'b1;
        #1 chk("rst_outst_cnt", outst_cnt, 0);
        chk("rst_mem_req", mem_req, 0);
        cycle();

        // single inst read
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
        #1 chk("t1_inst_addr_ok", inst_addr_ok, 1);
        cycle();
        set_idle();
        mem_data_ok = 1'b1; mem_rdata = 32'h0280_0401;
        #1 chk("t1_inst_data_ok", inst_data_ok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h0280_0401);
        cycle();
        set_idle();
        cycle();

        // collision: data first, then inst; responses route data then inst
        inst_req = 1'b1; inst_addr = 32'h1c00_0008;
        data_req = 1'b1; data_addr = 32'h0000_1000; mem_addr_ok = 1'b1;
        #1 chk("col_data_first", data_addr_ok, 1);
        chk("col_inst_wait", inst_addr_ok, 0);
        cycle();
        data_req = 1'b0;
        #1 chk("col_inst_next", inst_addr_ok, 1);
        cycle();
        set_idle();
        mem_data_ok = 1'b1;
        #1 chk("col_rsp0_data", data_data_ok, 1);
        cycle();
        #1 chk("col_rsp1_inst", inst_data_ok, 1);
        cycle();
        drain();

        // hold stability
        inst_req = 1'b1; inst_addr = 32'h1c00_0004;
        cycle();
        data_req = 1'b1; data_addr = 32'h0000_2000;
        cycle();
        #1 chk("hold_addr", mem_addr, 32'h1c00_0004);
        cycle();
        mem_addr_ok = 1'b1;
        #1 chk("hold_inst_acc", inst_addr_ok, 1);
        cycle();
        inst_req = 1'b0;
        #1 chk("hold_data_acc", data_addr_ok, 1);
        cycle();
        drain();

        // full backpressure
        data_req = 1'b1; data_addr = 32'h0000_3000; mem_addr_ok = 1'b1;
        cycle();
        data_addr = 32'h0000_3004;
        cycle();
        data_addr = 32'h0000_3008;
        #1 chk("full_mem_req", mem_req, 0);
        chk("full_addr_ok", data_addr_ok, 0);
        cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        #1 chk("full_pop_no_push", data_addr_ok, 0);
        cycle();
        mem_data_ok = 1'b0;
        #1 chk("full_push_next", data_addr_ok, 1);
        cycle();
        drain();

        // write tracking
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_wdata = 32'hdead_beef; data_addr = 32'h0000_0010; mem_addr_ok = 1'b1;
        #1 chk("wr_mem_wr", mem_wr, 1);
        chk("wr_mem_wstrb", mem_wstrb, 4'b0011);
        chk("wr_mem_wdata", mem_wdata, 32'hdead_beef);
        chk("wr_mem_addr", mem_addr, 32'h0000_0010);
        cycle();
        set_idle();
        mem_data_ok = 1'b1;
        #1 chk("wr_data_ok", data_data_ok, 1);
        chk("wr_no_inst_ok", inst_data_ok, 0);
        cycle();
        drain();

        // reset mid-flight, then a stray response
        data_req = 1'b1; data_addr = 32'h0000_4000; mem_addr_ok = 1'b1;
        cycle();
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c00_0010;
        cycle();
        set_idle();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        #1 chk("midrst_cnt", outst_cnt, 0);
        chk("midrst_mem_req", mem_req, 0);
        cycle();
        mem_data_ok = 1'b1;
        #1 chk("stray_inst_ok", inst_data_ok, 0);
        chk("stray_data_ok", data_data_ok, 0);
        cycle();
        set_idle();

        // randomized traffic with occasional resets
        ipend = 1'b0;
        dpend = 1'b0;
        for (int c = 0; c < 800; c++) begin
            resetn = ($urandom_range(0, 99) != 0);
            if (!resetn) begin
                ipend = 1'b0; dpend = 1'b0; inst_req = 1'b0; data_req = 1'b0;
            end else begin
                if (!ipend && $urandom_range(0, 2) == 0) begin
                    ipend = 1'b1; inst_req = 1'b1; inst_addr = $urandom & 32'hffff_fffc;
                end
                if (!dpend && $urandom_range(0, 2) == 0) begin
                    dpend = 1'b1; data_req = 1'b1; data_wr = 1'($urandom);
                    data_wstrb = SW'($urandom); data_addr = $urandom; data_wdata = $urandom;
                end
            end
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata   = $urandom;
            cycle();
            if (acc_inst) begin ipend = 1'b0; inst_req = 1'b0; end
            if (acc_data) begin dpend = 1'b0; data_req = 1'b0; end
        end
        resetn = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
